// File: rtl/vga_pkg.sv
// Shared VRAM geometry, tile-address/colour types and the rectangle-filler state set.
package vga_pkg;

  localparam int unsigned DEF_TILES_X = 40;
  localparam int unsigned DEF_TILES_Y = 30;
  localparam int unsigned VRAM_DEPTH  = DEF_TILES_X * DEF_TILES_Y;

  typedef logic [10:0] vaddr_t;
  typedef logic [1:0]  color_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_FILL,
    S_DONE
  } state_t;

  // Start address of a rectangle as shift-and-add over the five row bits.
  function automatic vaddr_t tile_addr(input logic [4:0] row, input logic [5:0] col,
                                       input int unsigned tiles_x);
    vaddr_t acc;
    acc = {5'b0, col};
    for (int unsigned i = 0; i < 5; i++) begin
      if (row[i]) acc = acc + vaddr_t'(tiles_x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vram_rect_filler_if.sv
// Command, VGA-sync and VRAM-write signals of the rectangle filler, bundled as one port.
interface vram_rect_filler_if;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [5:0]          cmd_x0;
  logic [4:0]          cmd_y0;
  logic [5:0]          cmd_w;
  logic [4:0]          cmd_h;
  vga_pkg::color_t     cmd_color;
  logic                cmd_sync;
  logic                vsync_ready;
  logic                vram_we;
  vga_pkg::vaddr_t     vram_addr;
  vga_pkg::color_t     vram_data;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_sync, vsync_ready,
    input  cmd_ready, vram_we, vram_addr, vram_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, cmd_sync, vsync_ready,
    output cmd_ready, vram_we, vram_addr, vram_data, busy, done, err
  );

endinterface

// File: rtl/rect_clip.sv
// Combinational rectangle check: rejects off-screen or empty commands, clips to screen edge.
module rect_clip
  import vga_pkg::*;
#(
  parameter int unsigned TILES_X = DEF_TILES_X,
  parameter int unsigned TILES_Y = DEF_TILES_Y
) (
  input  logic [5:0] i_x0,
  input  logic [4:0] i_y0,
  input  logic [5:0] i_w,
  input  logic [4:0] i_h,
  output logic       o_reject,
  output logic [5:0] o_w_eff,
  output logic [4:0] o_h_eff
);

  localparam logic [6:0] LX = 7'(TILES_X);
  localparam logic [5:0] LY = 6'(TILES_Y);

  logic [6:0] w_x_rem;
  logic [5:0] w_y_rem;

  always_comb begin
    w_x_rem  = LX - {1'b0, i_x0};
    w_y_rem  = LY - {1'b0, i_y0};
    o_reject = ({1'b0, i_x0} >= LX) || ({1'b0, i_y0} >= LY) || (i_w == '0) || (i_h == '0);
    o_w_eff  = ({1'b0, i_w} < w_x_rem) ? i_w : 6'(w_x_rem);
    o_h_eff  = ({1'b0, i_h} < w_y_rem) ? i_h : 5'(w_y_rem);
  end

endmodule

// File: rtl/vram_rect_filler.sv
// Tile-rectangle fill engine: one VRAM write per cycle, row-major, optionally gated on vblank.
module vram_rect_filler
  import vga_pkg::*;
#(
  parameter int unsigned TILES_X = DEF_TILES_X,
  parameter int unsigned TILES_Y = DEF_TILES_Y
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  vram_rect_filler_if.slave bus
);

  localparam vaddr_t ROW_STEP = vaddr_t'(TILES_X);

  state_t     r_state;
  state_t     w_state_nxt;
  color_t     r_color;
  logic       r_reject;
  logic [5:0] r_w_eff;
  logic [4:0] r_h_eff;
  logic [5:0] r_col;
  logic [4:0] r_row;
  vaddr_t     r_addr;
  vaddr_t     r_row_base;

  logic       w_reject;
  logic [5:0] w_w_eff;
  logic [4:0] w_h_eff;
  vaddr_t     w_start;
  logic       w_last_col;
  logic       w_last_row;

  // Clip looks at the live command so the accept edge can already pick FILL/DONE;
  // its results are captured together with the colour on that same edge.
  rect_clip #(
    .TILES_X(TILES_X),
    .TILES_Y(TILES_Y)
  ) u_clip (
    .i_x0    (bus.cmd_x0),
    .i_y0    (bus.cmd_y0),
    .i_w     (bus.cmd_w),
    .i_h     (bus.cmd_h),
    .o_reject(w_reject),
    .o_w_eff (w_w_eff),
    .o_h_eff (w_h_eff)
  );

  assign w_start    = w_reject ? '0 : tile_addr(bus.cmd_y0, bus.cmd_x0, TILES_X);
  assign w_last_col = (r_col == r_w_eff - 6'd1);
  assign w_last_row = (r_row == r_h_eff - 5'd1);

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (w_reject)          w_state_nxt = S_DONE;
          else if (bus.cmd_sync) w_state_nxt = S_WAIT_VS;
          else                   w_state_nxt = S_FILL;
        end
      end
      S_WAIT_VS: if (bus.vsync_ready) w_state_nxt = S_FILL;
      S_FILL:    if (w_last_col && w_last_row) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_color    <= '0;
      r_reject   <= 1'b0;
      r_w_eff    <= '0;
      r_h_eff    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_addr     <= '0;
      r_row_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_color    <= bus.cmd_color;
            r_reject   <= w_reject;
            r_w_eff    <= w_w_eff;
            r_h_eff    <= w_h_eff;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= w_start;
            r_row_base <= w_start;
          end
        end
        S_FILL: begin
          if (!w_last_col) begin
            r_col  <= r_col + 6'd1;
            r_addr <= r_addr + 11'd1;
          end else if (!w_last_row) begin
            r_col      <= '0;
            r_row      <= r_row + 5'd1;
            r_row_base <= r_row_base + ROW_STEP;
            r_addr     <= r_row_base + ROW_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.vram_we   = (r_state == S_FILL);
  assign bus.vram_addr = r_addr;
  assign bus.vram_data = r_color;
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = (r_state == S_DONE) && r_reject;

endmodule
